invntt_ctrl: RTL and testbench

Sequencer that runs one complete inverse-NTT job on the `invntt` engine. It streams 2^DEPTH 16-bit coefficients from a pair-wide source memory into the engine and drives the engine's `set`/`readin`/`full_in`/`cal_en`/`readout` controls. It then writes the result pairs back to a destination memory and reports completion or timeout. It sits between the polynomial RAMs and `invntt`, and replaces the hand-driven bench sequencing.

---
 rtl/invntt_ctrl.sv | 178 +++++++++++++++++
 tb/tb_invntt_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/invntt_ctrl.sv
// Job sequencer for the invntt engine: loads 2^DEPTH coefficients pair by pair,
// runs the transform with a timeout guard, and writes the result pairs back.
module invntt_ctrl #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             job_done,
   output logic             err,
   output logic             src_rd,
   output logic [DEPTH-2:0] src_addr,
   input  logic [31:0]      src_data,
   output logic             dst_we,
   output logic [DEPTH-1:0] dst_addr,
   output logic [31:0]      dst_data,
   output logic             set,
   output logic             readin,
   output logic             full_in,
   output logic             cal_en,
   output logic             readout,
   output logic [15:0]      din_1,
   output logic [15:0]      din_2,
   output logic [DEPTH-1:0] in_index,
   input  logic [15:0]      dout_1,
   input  logic [15:0]      dout_2,
   input  logic [DEPTH-1:0] out_index,
   input  logic             readin_ok,
   input  logic             eng_done
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, LOAD, FLUSH, COMPUTE, DRAIN, FINISH
   } state_t;

   state_t           state, state_nx;
   logic [DEPTH-2:0] p, w;
   logic [TW-1:0]    tcnt;
   logic             vld_p0;
   logic [15:0]      lo_p0, hi_p0;
   logic [DEPTH-1:0] idx_p0;
   logic             accept;
   logic             tmo_hit;

   assign accept  = (state == IDLE) && start && !abort;
   assign tmo_hit = (state == COMPUTE) && !eng_done && (tcnt == T_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         p      <= '0;
         w      <= '0;
         tcnt   <= '0;
         err    <= 1'b0;
         vld_p0 <= 1'b0;
      end else begin
         state  <= state_nx;
         vld_p0 <= src_rd;
         if (accept) begin
            p   <= '0;
            w   <= '0;
            err <= 1'b0;
         end else begin
            if (src_rd && !(&p))
               p <= p + 1'b1;
            if (dst_we && !(&w))
               w <= w + 1'b1;
            if (tmo_hit && !abort)
               err <= 1'b1;
         end
         if (state == COMPUTE && !eng_done)
            tcnt <= tcnt + 1'b1;
         else
            tcnt <= '0;
      end
   end

   // Stage p0: index captured with the read, data captured when it returns
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         idx_p0 <= '0;
         lo_p0  <= '0;
         hi_p0  <= '0;
      end else begin
         if (src_rd)
            idx_p0 <= {p, 1'b0};
         if (vld_p0) begin
            lo_p0 <= src_data[15:0];
            hi_p0 <= src_data[31:16];
         end
      end
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      job_done = 1'b0;
      src_rd   = 1'b0;
      src_addr = '0;
      dst_we   = 1'b0;
      dst_addr = '0;
      dst_data = '0;
      set      = 1'b0;
      readin   = 1'b0;
      full_in  = 1'b0;
      cal_en   = 1'b0;
      readout  = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nx = SETUP;
         end
         SETUP: begin
            set      = 1'b1;
            readin   = 1'b1;
            state_nx = LOAD;
         end
         LOAD: begin
            set      = 1'b1;
            readin   = 1'b1;
            src_rd   = readin_ok;
            src_addr = p;
            if (readin_ok && (&p))
               state_nx = FLUSH;
         end
         FLUSH: begin
            set      = 1'b1;
            readin   = 1'b1;
            full_in  = 1'b1;
            state_nx = COMPUTE;
         end
         COMPUTE: begin
            set     = 1'b1;
            cal_en  = 1'b1;
            readout = 1'b1;
            if (eng_done)
               state_nx = DRAIN;
            else if (tcnt == T_LAST)
               state_nx = FINISH;
         end
         DRAIN: begin
            set      = 1'b1;
            readout  = 1'b1;
            dst_we   = 1'b1;
            dst_addr = out_index;
            dst_data = {dout_1, dout_2};
            if (&w)
               state_nx = FINISH;
         end
         FINISH: begin
            job_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (abort)
         state_nx = IDLE;
   end

   // Returning read data bypasses the hold registers so din is valid the cycle after src_rd
   always_comb begin
      din_1    = '0;
      din_2    = '0;
      in_index = '0;
      if (state != IDLE) begin
         in_index = idx_p0;
         din_1    = vld_p0 ? src_data[31:16] : hi_p0;
         din_2    = vld_p0 ? src_data[15:0]  : lo_p0;
      end
   end

endmodule

// File: tb/tb_invntt_ctrl.sv
// Randomized bench for invntt_ctrl: memory and engine models plus a job-level
// reference for read order, input pairs, write-back contents and latency.
module tb_invntt_ctrl;

   localparam int DEPTH = 8;
   localparam int N     = 1 << DEPTH;
   localparam int NP    = N / 2;
   localparam int TO    = 64;
   localparam int C     = 20;
   localparam int HMAX  = 20000;

   logic             clk, reset, start, abort;
   logic             busy, job_done, err;
   logic             src_rd;
   logic [DEPTH-2:0] src_addr;
   logic [31:0]      src_data;
   logic             dst_we;
   logic [DEPTH-1:0] dst_addr;
   logic [31:0]      dst_data;
   logic             set, readin, full_in, cal_en, readout;
   logic [15:0]      din_1, din_2;
   logic [DEPTH-1:0] in_index;
   logic [15:0]      dout_1, dout_2;
   logic [DEPTH-1:0] out_index;
   logic             readin_ok, eng_done;

   invntt_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy), .job_done(job_done), .err(err),
      .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
      .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data),
      .set(set), .readin(readin), .full_in(full_in), .cal_en(cal_en), .readout(readout),
      .din_1(din_1), .din_2(din_2), .in_index(in_index),
      .dout_1(dout_1), .dout_2(dout_2), .out_index(out_index),
      .readin_ok(readin_ok), .eng_done(eng_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---- models ----
   logic [15:0] coef [N];
   int          cyc = 0;
   int          ok_mode = 0;
   bit          eng_en = 1'b1;
   int          cal_cnt = 0;
   logic [6:0]  wcnt = '0;
   localparam logic [15:0] XK = 16'hA5C3;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (src_rd) src_data <= {coef[2*src_addr+1], coef[2*src_addr]};
      else        src_data <= 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (!cal_en) cal_cnt <= 0;
      else         cal_cnt <= cal_cnt + 1;
      if (!busy)       wcnt <= '0;
      else if (dst_we) wcnt <= wcnt + 1'b1;
   end

   assign eng_done  = eng_en && cal_en && (cal_cnt == C - 1);
   assign out_index = {wcnt, 1'b0};
   assign dout_2    = coef[2*wcnt] ^ XK;
   assign dout_1    = coef[2*wcnt+1] ^ XK;

   initial begin
      readin_ok = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ok_mode)
            0:       readin_ok = 1'b1;
            1:       readin_ok = ~cyc[0];
            default: readin_ok = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---- monitor ----
   logic [6:0]  rd_q [$];
   logic [39:0] in_q [$];
   logic [39:0] wr_q [$];
   logic [39:0] full_rec;
   bit          ok_hist [HMAX];
   int          full_cnt, done_cnt, done_cyc;
   logic        done_err;
   bit          prev_rd;

   always @(negedge clk) begin
      if (cyc < HMAX) ok_hist[cyc] = readin_ok;
      if (prev_rd) in_q.push_back({in_index, din_1, din_2});
      prev_rd = src_rd;
      if (src_rd) rd_q.push_back(src_addr);
      if (full_in) begin
         full_cnt++;
         full_rec = {in_index, din_1, din_2};
      end
      if (dst_we) wr_q.push_back({dst_addr, dst_data});
      if (job_done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = err;
      end
   end

   task automatic new_coefs();
      for (int i = 0; i < N; i++) coef[i] = 16'($urandom);
   endtask

   task automatic launch(output int s);
      @(posedge clk);
      #1;
      rd_q.delete(); in_q.delete(); wr_q.delete();
      full_cnt = 0; done_cnt = 0; done_cyc = -1; prev_rd = 1'b0;
      start = 1'b1;
      s = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
   endtask

   // Job-level expectations derived from the sequencing rules
   task automatic check_job(input string nm, input int s, input bit tmo);
      int L, k, n, exp_done;
      check({nm, "_rd_count"}, rd_q.size(), NP);
      n = (rd_q.size() < NP) ? rd_q.size() : NP;
      for (int i = 0; i < n; i++)
         if (rd_q[i] !== 7'(i)) begin check({nm, "_rd_addr"}, rd_q[i], i); break; end
      check({nm, "_in_count"}, in_q.size(), NP);
      n = (in_q.size() < NP) ? in_q.size() : NP;
      for (int i = 0; i < n; i++)
         if (in_q[i] !== {8'(2*i), coef[2*i+1], coef[2*i]}) begin
            check({nm, "_in_pair"}, in_q[i], {8'(2*i), coef[2*i+1], coef[2*i]});
            break;
         end
      check({nm, "_full_count"}, full_cnt, 1);
      check({nm, "_full_pair"}, full_rec, {8'(N-2), coef[N-1], coef[N-2]});
      check({nm, "_wr_count"}, wr_q.size(), tmo ? 0 : NP);
      n = (wr_q.size() < NP) ? wr_q.size() : NP;
      for (int i = 0; i < n; i++)
         if (wr_q[i] !== {8'(2*i), coef[2*i+1] ^ XK, coef[2*i] ^ XK}) begin
            check({nm, "_wr_data"}, wr_q[i], {8'(2*i), coef[2*i+1] ^ XK, coef[2*i] ^ XK});
            break;
         end
      L = 0; k = 0;
      while (k < NP && L < 5000 && (s + 2 + L) < HMAX) begin
         if (ok_hist[s + 2 + L]) k++;
         L++;
      end
      exp_done = s + 1 + L + 1 + (tmo ? TO : C) + (tmo ? 0 : NP) + 1;
      check({nm, "_done_count"}, done_cnt, 1);
      check({nm, "_done_cycle"}, done_cyc, exp_done);
      check({nm, "_err"}, done_err, tmo);
   endtask

   int          s;
   logic [39:0] saved_wr [$];
   int          saved_lat;

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      done_cnt = 0; full_cnt = 0; done_cyc = -1; prev_rd = 1'b0;
      new_coefs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_job_done", job_done, 0);
      check("rst_err", err, 0);
      check("rst_src_rd", src_rd, 0);
      check("rst_ctrl", {set, readin, full_in, cal_en, readout}, 0);
      check("rst_dst", {dst_we, dst_addr, dst_data}, 0);
      check("rst_din", {in_index, din_1, din_2}, 0);
      @(posedge clk); #1 reset = 1'b1;

      // nominal job, then a back-to-back repeat of it
      ok_mode = 0;
      launch(s); wait_done(); check_job("jobA", s, 0);
      saved_wr = wr_q; saved_lat = done_cyc - s;
      launch(s); wait_done(); check_job("jobA2", s, 0);
      check("b2b_latency", done_cyc - s, saved_lat);
      check("b2b_wr_size", wr_q.size(), saved_wr.size());
      if (wr_q.size() == saved_wr.size())
         for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== saved_wr[i]) begin check("b2b_wr", wr_q[i], saved_wr[i]); break; end

      // stalled loads: alternating then random readin_ok
      new_coefs(); ok_mode = 1;
      launch(s); wait_done(); check_job("jobB", s, 0);
      new_coefs(); ok_mode = 2;
      launch(s); wait_done(); check_job("jobC", s, 0);

      // timeout, then a clean job clears err
      ok_mode = 0; eng_en = 1'b0;
      launch(s); wait_done(); check_job("tmo", s, 1);
      @(negedge clk);
      check("tmo_err_sticky", err, 1);
      eng_en = 1'b1;
      launch(s);
      @(negedge clk);
      check("err_cleared", err, 0);
      wait_done(); check_job("after_tmo", s, 0);

      // asynchronous reset in the middle of LOAD
      new_coefs();
      launch(s);
      for (int i = 0; i < 2000 && rd_q.size() < 40; i++) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_src", {src_rd, src_addr}, 0);
      check("mid_rst_ctrl", {set, readin, full_in, cal_en, readout}, 0);
      check("mid_rst_din", {in_index, din_1, din_2}, 0);
      @(posedge clk); #1 reset = 1'b1;
      launch(s); wait_done(); check_job("after_rst", s, 0);

      // abort during DRAIN with a stray start while busy
      launch(s);
      for (int i = 0; i < 2000 && wr_q.size() < 5; i++) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 2000 && wr_q.size() < 10; i++) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      #3;
      check("abort_busy", busy, 0);
      check("abort_dst_we", dst_we, 0);
      repeat (30) @(posedge clk);
      #1;
      check("abort_wr_count", wr_q.size(), 11);
      check("abort_no_done", done_cnt, 0);
      check("abort_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
